sort_result_streamer: RTL

- Consumer end of the top-N sorter interface.
- On the sorter's one-cycle sort_finish pulse, snapshots the OUT_NUM sorted (value, address) pairs.
- Streams the non-empty entries out in ascending rank order over a valid/ready handshake, then pulses a done strobe with the entry count.
- Sits between the sorter and the downstream bloom/peak-processing logic, so the sorter can immediately start its next scan.

---
 rtl/sort_pkg.sv | 19 +
 rtl/sort_valid_count.sv | 31 +++
 rtl/sort_result_streamer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared constants and state encoding for the sort result streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sort_pkg;

  localparam int OUT_NUM     = 4;
  localparam int DATA_LENGTH = 14;
  localparam int NUM_WIDTH   = 6;

  // A slot holding this value carries no result.
  localparam logic [DATA_LENGTH-1:0] EMPTY_DATA = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sort_valid_count.sv
// Counts the leading non-empty slots of a sorted snapshot (stops at the first empty one).
// Latency: combinational.
// Backpressure: none; the result is registered by the parent at capture.
module sort_valid_count #(
  parameter int OUT_NUM     = 4,
  parameter int DATA_LENGTH = 14,
  parameter int CNT_WIDTH   = 3
) (
  input  logic [DATA_LENGTH-1:0] i_data [OUT_NUM],
  output logic [CNT_WIDTH-1:0]   o_count
);

  logic [CNT_WIDTH-1:0] w_count;
  logic                 w_stop;

  // Walk slots in rank order; anything after the first empty slot is ignored.
  always_comb begin
    w_count = '0;
    w_stop  = 1'b0;
    for (int i = 0; i < OUT_NUM; i++) begin
      if (!w_stop && (i_data[i] != {DATA_LENGTH{1'b1}})) begin
        w_count = w_count + CNT_WIDTH'(1);
      end else begin
        w_stop = 1'b1;
      end
    end
  end

  assign o_count = w_count;

endmodule

// File: rtl/sort_result_streamer.sv
// Snapshots the top-N sorter result on sort_finish and streams non-empty entries in rank order.
// Latency: first beat one cycle after sort_finish; one beat per cycle while out_ready is high.
// Backpressure: beats hold stable while out_ready is low; sort_finish during a drain is dropped and flagged.
module sort_result_streamer #(
  parameter int OUT_NUM     = sort_pkg::OUT_NUM,
  parameter int DATA_LENGTH = sort_pkg::DATA_LENGTH,
  parameter int NUM_WIDTH   = sort_pkg::NUM_WIDTH,
  parameter int RANK_WIDTH  = $clog2(OUT_NUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sort_finish,
  input  logic [DATA_LENGTH-1:0] sorted_data [OUT_NUM],
  input  logic [NUM_WIDTH-1:0]   sorted_addr [OUT_NUM],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LENGTH-1:0] out_data,
  output logic [NUM_WIDTH-1:0]   out_addr,
  output logic [RANK_WIDTH-1:0]  out_rank,
  output logic                   out_last,
  output logic                   drain_done,
  output logic [RANK_WIDTH:0]    entry_count,
  output logic                   busy,
  output logic                   overrun
);

  import sort_pkg::*;

  localparam int CNT_WIDTH = RANK_WIDTH + 1;

  state_t                 r_state;
  logic [DATA_LENGTH-1:0] r_snap_data [OUT_NUM];
  logic [NUM_WIDTH-1:0]   r_snap_addr [OUT_NUM];
  logic [CNT_WIDTH-1:0]   r_n;
  logic [RANK_WIDTH-1:0]  r_rank;
  logic                   r_valid;
  logic [DATA_LENGTH-1:0] r_data;
  logic [NUM_WIDTH-1:0]   r_addr;
  logic                   r_last;
  logic                   r_done;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   r_busy;
  logic                   r_overrun;

  logic [CNT_WIDTH-1:0]   w_n;
  logic                   w_accept;
  logic [RANK_WIDTH-1:0]  w_next_rank;
  logic                   w_next_last;

  sort_valid_count #(
    .OUT_NUM     (OUT_NUM),
    .DATA_LENGTH (DATA_LENGTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_valid_count (
    .i_data  (sorted_data),
    .o_count (w_n)
  );

  // out_valid is a pure register, so out_ready only influences the next state.
  assign w_accept    = r_valid & out_ready;
  assign w_next_rank = r_rank + RANK_WIDTH'(1);
  assign w_next_last = ({1'b0, w_next_rank} == (r_n - CNT_WIDTH'(1)));

  // Capture/drain FSM; every output is a register so reset clears the stream immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      for (int i = 0; i < OUT_NUM; i++) begin
        r_snap_data[i] <= '1;
        r_snap_addr[i] <= '0;
      end
      r_n       <= '0;
      r_rank    <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_addr    <= '0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        SEND: begin
          // The snapshot belongs to the drain in progress; a new result is lost.
          if (sort_finish) begin
            r_overrun <= 1'b1;
          end
          if (w_accept) begin
            if (r_last) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_data  <= '0;
              r_addr  <= '0;
              r_rank  <= '0;
              r_done  <= 1'b1;
              r_count <= r_n;
            end else begin
              r_rank  <= w_next_rank;
              r_data  <= r_snap_data[w_next_rank];
              r_addr  <= r_snap_addr[w_next_rank];
              r_last  <= w_next_last;
            end
          end
        end
        default: begin
          // IDLE and the single DONE cycle both accept a fresh snapshot.
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_count <= '0;
          r_busy  <= 1'b0;
          if (sort_finish) begin
            r_snap_data <= sorted_data;
            r_snap_addr <= sorted_addr;
            r_n         <= w_n;
            r_busy      <= 1'b1;
            if (w_n != '0) begin
              r_state <= SEND;
              r_valid <= 1'b1;
              r_rank  <= '0;
              r_data  <= sorted_data[0];
              r_addr  <= sorted_addr[0];
              r_last  <= (w_n == CNT_WIDTH'(1));
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_count <= '0;
            end
          end
        end
      endcase
    end
  end

  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign out_addr    = r_addr;
  assign out_rank    = r_rank;
  assign out_last    = r_last;
  assign drain_done  = r_done;
  assign entry_count = r_count;
  assign busy        = r_busy;
  assign overrun     = r_overrun;

endmodule
